// File: rtl/add_1p_arbiter_if.sv
// add_1p_arbiter_if: request, adder-side and response signals that connect
// the client blocks, the round-robin arbiter and the shared add_1p instance.
// Optional macro ADD_1P_ARB_OVF_EN adds the resp_ovf carry-out strobe.
interface add_1p_arbiter_if #(
   parameter int WIDTH = 15,
   parameter int NREQ  = 4
);
   localparam int IDW = $clog2(NREQ);

   // Request side: one operand pair per requester, packed i*WIDTH +: WIDTH.
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_x;
   logic [NREQ*WIDTH-1:0] req_y;

   // Adder side: registered operands out, pipelined sum back.
   logic [WIDTH-1:0]      add_x;
   logic [WIDTH-1:0]      add_y;
   logic [WIDTH-1:0]      add_sum;

   // Response side: one-hot single-cycle strobe plus owner ID and result.
   logic [NREQ-1:0]       resp_valid;
   logic [IDW-1:0]        resp_id;
   logic [WIDTH-1:0]      resp_sum;
`ifdef ADD_1P_ARB_OVF_EN
   logic                  resp_ovf;
`endif

   // Client/environment view: issues requests, returns the adder sum.
   modport master (
      output req_valid, req_x, req_y, add_sum,
      input  req_ready, add_x, add_y, resp_valid, resp_id, resp_sum
`ifdef ADD_1P_ARB_OVF_EN
      , input resp_ovf
`endif
   );

   // Arbiter view.
   modport slave (
      input  req_valid, req_x, req_y, add_sum,
      output req_ready, add_x, add_y, resp_valid, resp_id, resp_sum
`ifdef ADD_1P_ARB_OVF_EN
      , output resp_ovf
`endif
   );
endinterface

// File: rtl/add_1p_arbiter.sv
// add_1p_arbiter: round-robin scheduler sharing one pipelined add_1p among
// NREQ requesters. One operand pair is accepted per cycle, a requester tag
// rides a LAT+1 deep shift pipe alongside the adder, and each sum is routed
// back to its issuer with a one-hot strobe, strictly in acceptance order.
// Optional macro ADD_1P_ARB_OVF_EN: tag also carries operand MSBs and the
// response gains resp_ovf, the unsigned carry-out of the addition.
module add_1p_arbiter #(
   parameter int WIDTH = 15,
   parameter int NREQ  = 4,
   parameter int LAT   = 2
) (
   input  logic            clk,
   input  logic            rst,
   add_1p_arbiter_if.slave bus
);
   localparam int             IDW    = $clog2(NREQ);
   localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);

   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
`ifdef ADD_1P_ARB_OVF_EN
      logic           x_msb;
      logic           y_msb;
`endif
   } tag_t;

   logic [IDW-1:0]   ptr;
   logic [NREQ-1:0]  rot_valid;
   logic             gnt_vld;
   logic [IDW-1:0]   gnt_off;
   logic [IDW:0]     gnt_raw;
   logic [IDW-1:0]   gnt_id;
   logic [WIDTH-1:0] gnt_x;
   logic [WIDTH-1:0] gnt_y;
   tag_t             tag_in;
   tag_t             tag_q [LAT+1];
   logic [NREQ-1:0]  resp_oh;

   // Round-robin search: rotate the valid vector so ptr sits at bit 0, take
   // the lowest set bit, then rotate the winner's offset back into an ID.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the block can leave it unassigned and infer a latch.
      rot_valid = NREQ'({bus.req_valid, bus.req_valid} >> ptr);
      gnt_vld   = 1'b0;
      gnt_off   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_vld && rot_valid[k]) begin
            gnt_vld = 1'b1;
            gnt_off = IDW'(k);
         end
      end
      gnt_raw = {1'b0, ptr} + {1'b0, gnt_off};
      gnt_id  = (gnt_raw >= NREQ_W) ? IDW'(gnt_raw - NREQ_W) : IDW'(gnt_raw);
      if (rst) begin
         gnt_vld = 1'b0;
      end
   end

   // One-hot ready, operand mux and the tag entering the pipe.
   always_comb begin
      bus.req_ready = '0;
      gnt_x         = '0;
      gnt_y         = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_id == IDW'(k)) begin
            bus.req_ready[k] = gnt_vld;
            gnt_x            = bus.req_x[k*WIDTH +: WIDTH];
            gnt_y            = bus.req_y[k*WIDTH +: WIDTH];
         end
      end
      tag_in     = '0;
      tag_in.vld = gnt_vld;
      tag_in.id  = gnt_id;
`ifdef ADD_1P_ARB_OVF_EN
      tag_in.x_msb = gnt_x[WIDTH-1];
      tag_in.y_msb = gnt_y[WIDTH-1];
`endif
   end

   // Accept side: capture granted operands and advance the pointer past the
   // winner; both hold when nobody is granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         bus.add_x <= '0;
         bus.add_y <= '0;
      end else if (gnt_vld) begin
         // NOTE: registers use <= so each flop samples pre-edge values no
         // matter how the always blocks are ordered by the simulator.
         bus.add_x <= gnt_x;
         bus.add_y <= gnt_y;
         ptr       <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      end
   end

   // Tag pipe: LAT+1 stages, shifts every edge; an idle edge inserts a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: this small array is reset element by element because a stale
         // valid bit would emit a phantom response; bulk data storage that
         // carries no control meaning is normally left unreset.
         for (int s = 0; s <= LAT; s++) begin
            tag_q[s] <= '0;
         end
      end else begin
         tag_q[0] <= tag_in;
         for (int s = 1; s <= LAT; s++) begin
            tag_q[s] <= tag_q[s-1];
         end
      end
   end

   // Decode the last tag stage into the one-hot response strobe.
   always_comb begin
      resp_oh = '0;
      for (int k = 0; k < NREQ; k++) begin
         resp_oh[k] = tag_q[LAT].vld && (tag_q[LAT].id == IDW'(k));
      end
   end

   // Response register: strobe for one cycle, ID/sum/ovf hold between results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.resp_valid <= '0;
         bus.resp_id    <= '0;
         bus.resp_sum   <= '0;
`ifdef ADD_1P_ARB_OVF_EN
         bus.resp_ovf   <= 1'b0;
`endif
      end else begin
         bus.resp_valid <= resp_oh;
         if (tag_q[LAT].vld) begin
            bus.resp_id  <= tag_q[LAT].id;
            bus.resp_sum <= bus.add_sum;
`ifdef ADD_1P_ARB_OVF_EN
            bus.resp_ovf <= (tag_q[LAT].x_msb & tag_q[LAT].y_msb) |
                            ((tag_q[LAT].x_msb ^ tag_q[LAT].y_msb) &
                             ~bus.add_sum[WIDTH-1]);
`endif
         end
      end
   end
endmodule
